lmac_reg_access_ctrl: RTL and testbench

// Parametrised register read/write master between a host request port and the LMAC register bus.

---
 rtl/lmac_reg_access_ctrl_if.sv | 38 +++
 rtl/lmac_reg_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_lmac_reg_access_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lmac_reg_access_ctrl_if.sv
// Bundle of host request/response handshake and LMAC register bus signals.
// The controller connects through the slave modport. The host together with
// the LMAC register block (or a model of both) connects through the master modport.
interface lmac_reg_access_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_rd_start;
   logic              reg_wr_start;
   logic              reg_rd_done_out;
   logic              reg_wr_done;
   logic [DATA_W-1:0] mac_regdout;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
             reg_rd_done_out, reg_wr_done, mac_regdout,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             host_addr, reg_wdata, reg_rd_start, reg_wr_start
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
             reg_rd_done_out, reg_wr_done, mac_regdout,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             host_addr, reg_wdata, reg_rd_start, reg_wr_start
   );
endinterface

// File: rtl/lmac_reg_access_ctrl.sv
// LMAC register access controller: takes one host read/write at a time,
// presents the address for a setup period, issues a one-cycle start pulse,
// waits for the matching done strobe (bounded by a timeout) and returns the
// result on a valid/ready response port.
module lmac_reg_access_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int SETUP_CYC   = 1,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  reg_clk,
   input  logic                  reset,
   lmac_reg_access_ctrl_if.slave bus,
   output logic                  busy,
   output logic [7:0]            timeout_cnt
);

   localparam int TMR_W   = $clog2(TIMEOUT_CYC + 1);
   localparam int SETUP_W = $clog2(SETUP_CYC + 1);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      ADDR  = 5'b00010,
      START = 5'b00100,
      WAIT  = 5'b01000,
      RESP  = 5'b10000
   } state_t;

   state_t              state_q, state_d;
   logic                wrReq_q, wrReq_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [SETUP_W-1:0]  setupCnt_q, setupCnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [DATA_W-1:0]   rspData_q, rspData_d;
   logic                rspErr_q, rspErr_d;
   logic [7:0]          timeoutCnt_q, timeoutCnt_d;
   logic                doneHit;

   // State and datapath registers, all cleared by the synchronous reset
   always_ff @(posedge reg_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wrReq_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         setupCnt_q   <= '0;
         timer_q      <= '0;
         rspData_q    <= '0;
         rspErr_q     <= 1'b0;
         timeoutCnt_q <= '0;
      end else begin
         state_q      <= state_d;
         wrReq_q      <= wrReq_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         setupCnt_q   <= setupCnt_d;
         timer_q      <= timer_d;
         rspData_q    <= rspData_d;
         rspErr_q     <= rspErr_d;
         timeoutCnt_q <= timeoutCnt_d;
      end
   end

   // Only the done strobe matching the latched transaction type completes it
   always_comb begin
      doneHit = wrReq_q ? bus.reg_wr_done : bus.reg_rd_done_out;
   end

   // Next-state logic; done is checked before timeout so a late done still wins
   always_comb begin
      state_d      = state_q;
      wrReq_d      = wrReq_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      setupCnt_d   = setupCnt_q;
      timer_d      = timer_q;
      rspData_d    = rspData_q;
      rspErr_d     = rspErr_q;
      timeoutCnt_d = timeoutCnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wrReq_d    = bus.req_wr;
               addr_d     = bus.req_addr;
               wdata_d    = bus.req_wdata;
               setupCnt_d = '0;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (setupCnt_q == SETUP_W'(SETUP_CYC - 1)) begin
               state_d = START;
            end else begin
               setupCnt_d = setupCnt_q + SETUP_W'(1);
            end
         end
         START: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            if (doneHit) begin
               rspData_d = wrReq_q ? '0 : bus.mac_regdout;
               rspErr_d  = 1'b0;
               state_d   = RESP;
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
               rspData_d = '1;
               rspErr_d  = 1'b1;
               if (timeoutCnt_q != 8'hFF) begin
                  timeoutCnt_d = timeoutCnt_q + 8'd1;
               end
               state_d   = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the registered state; address/data are zero in IDLE
   always_comb begin
      bus.req_ready    = (state_q == IDLE);
      busy             = (state_q != IDLE);
      bus.host_addr    = (state_q != IDLE) ? addr_q : '0;
      bus.reg_wdata    = ((state_q != IDLE) && wrReq_q) ? wdata_q : '0;
      bus.reg_rd_start = (state_q == START) && !wrReq_q;
      bus.reg_wr_start = (state_q == START) && wrReq_q;
      bus.rsp_valid    = (state_q == RESP);
      bus.rsp_data     = (state_q == RESP) ? rspData_q : '0;
      bus.rsp_err      = (state_q == RESP) && rspErr_q;
      timeout_cnt      = timeoutCnt_q;
   end

endmodule

// File: tb/tb_lmac_reg_access_ctrl.sv
// Self-checking bench for lmac_reg_access_ctrl: a vector table of directed
// transactions, hand-written reset/idle-strobe sequences, randomized
// transactions and a timeout-counter saturation run.
module tb_lmac_reg_access_ctrl;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 32;
   localparam int SETUP_CYC   = 2;
   localparam int TIMEOUT_CYC = 16;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          doneK;
      int          hold;
      bit          wrong;
      logic [31:0] expData;
      bit          expErr;
   } vec_t;

   logic       reg_clk = 1'b0;
   logic       reset;
   logic       busy;
   logic [7:0] timeout_cnt;
   int         cyc = 0;
   int         testsRun = 0;
   int         testsFailed = 0;
   int         expToCnt = 0;

   lmac_reg_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   lmac_reg_access_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .reg_clk(reg_clk),
      .reset(reset),
      .bus(bus.slave),
      .busy(busy),
      .timeout_cnt(timeout_cnt)
   );

   // Free-running clock and a cycle index of the last rising edge
   always #5 reg_clk = ~reg_clk;
   always @(posedge reg_clk) cyc <= cyc + 1;

   // Hard stop in case something wedges outside the bounded loops
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      bus.req_valid       = 1'b0;
      bus.req_wr          = 1'b0;
      bus.req_addr        = '0;
      bus.req_wdata       = '0;
      bus.rsp_ready       = 1'b0;
      bus.reg_rd_done_out = 1'b0;
      bus.reg_wr_done     = 1'b0;
      bus.mac_regdout     = '0;
   endtask

   // Runs one full transaction from IDLE; the LMAC side asserts the matching
   // done strobe on WAIT cycle doneK (0 = never), and the host stalls the
   // response for hold cycles while keeping a new request pending.
   task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int doneK, input int hold,
                                input bit wrong, input logic [31:0] expData, input bit expErr);
      int          acceptCyc, expStart, expRsp, startCyc, rdPulses, wrPulses, n, heldBad;
      logic [31:0] expWdata;
      expWdata = wr ? wdata : 32'h0;
      rdPulses = 0;
      wrPulses = 0;
      heldBad  = 0;
      startCyc = -1;
      n        = 0;
      checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.rsp_ready = 1'b0;
      @(negedge reg_clk);
      acceptCyc     = cyc;
      bus.req_valid = 1'b0;
      bus.req_wr    = ~wr;
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = $urandom;
      expStart = acceptCyc + SETUP_CYC;
      expRsp   = expStart + (expErr ? TIMEOUT_CYC : doneK) + 1;
      if (expErr) expToCnt = (expToCnt == 255) ? 255 : expToCnt + 1;
      while (bus.rsp_valid !== 1'b1 && n < 100) begin
         if (bus.host_addr !== addr || bus.reg_wdata !== expWdata || busy !== 1'b1 || bus.req_ready !== 1'b0)
            heldBad++;
         if (bus.reg_rd_start === 1'b1) begin rdPulses++; startCyc = cyc; end
         if (bus.reg_wr_start === 1'b1) begin wrPulses++; startCyc = cyc; end
         bus.reg_rd_done_out = 1'b0;
         bus.reg_wr_done     = 1'b0;
         bus.mac_regdout     = $urandom;
         if (doneK >= 1 && cyc == expStart + doneK) begin
            if (wr) bus.reg_wr_done = 1'b1;
            else begin
               bus.reg_rd_done_out = 1'b1;
               bus.mac_regdout     = rdata;
            end
         end else if (wrong && $urandom_range(0, 1) == 1) begin
            if (wr) bus.reg_rd_done_out = 1'b1;
            else    bus.reg_wr_done     = 1'b1;
         end
         @(negedge reg_clk);
         n++;
      end
      bus.reg_rd_done_out = 1'b0;
      bus.reg_wr_done     = 1'b0;
      checkOutput("rsp_within_bound", 32'(bus.rsp_valid), 32'd1);
      checkOutput("rsp_latency", 32'(cyc), 32'(expRsp));
      checkOutput("start_cycle", 32'(startCyc), 32'(expStart));
      checkOutput("rd_start_pulses", 32'(rdPulses), wr ? 32'd0 : 32'd1);
      checkOutput("wr_start_pulses", 32'(wrPulses), wr ? 32'd1 : 32'd0);
      checkOutput("rsp_data", bus.rsp_data, expData);
      checkOutput("rsp_err", 32'(bus.rsp_err), 32'(expErr));
      checkOutput("timeout_cnt", 32'(timeout_cnt), 32'(expToCnt));
      bus.req_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge reg_clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== expData || bus.rsp_err !== expErr ||
             bus.req_ready !== 1'b0 || bus.host_addr !== addr || busy !== 1'b1)
            heldBad++;
      end
      checkOutput("held_through_txn", 32'(heldBad), 32'd0);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge reg_clk);
      bus.rsp_ready = 1'b0;
      checkOutput("idle_after_rsp",
                  32'({busy, bus.rsp_valid, bus.host_addr != 16'h0, bus.reg_wdata != 32'h0, bus.req_ready}),
                  32'b00001);
   endtask

   vec_t        vecs[6];
   bit          rWr;
   logic [15:0] rAddr;
   logic [31:0] rWdata, rRdata, rExpData;
   int          rK, rHold, idleBad;
   bit          rWrong, rExpErr;

   initial begin
      vecs[0] = '{1'b0, 16'h0040, 32'h0,        32'hA5A51234, 3,  0, 1'b0, 32'hA5A51234, 1'b0};
      vecs[1] = '{1'b1, 16'h0010, 32'h000000FF, 32'h0,        1,  0, 1'b1, 32'h00000000, 1'b0};
      vecs[2] = '{1'b0, 16'h0100, 32'h0,        32'h12345678, 0,  0, 1'b0, 32'hFFFFFFFF, 1'b1};
      vecs[3] = '{1'b0, 16'h0200, 32'h0,        32'h0BADF00D, 16, 0, 1'b1, 32'h0BADF00D, 1'b0};
      vecs[4] = '{1'b0, 16'h0300, 32'h0,        32'hCAFEBABE, 2,  5, 1'b0, 32'hCAFEBABE, 1'b0};
      vecs[5] = '{1'b1, 16'hBEEF, 32'h5A5A5A5A, 32'h0,        17, 2, 1'b0, 32'hFFFFFFFF, 1'b1};

      idleInputs();
      reset = 1'b1;
      repeat (2) @(negedge reg_clk);
      reset = 1'b0;
      checkOutput("reset_ctrl",
                  32'({bus.req_ready, busy, bus.rsp_valid, bus.rsp_err, bus.reg_rd_start, bus.reg_wr_start}),
                  32'b100000);
      checkOutput("reset_host_addr", 32'(bus.host_addr), 32'h0);
      checkOutput("reset_reg_wdata", bus.reg_wdata, 32'h0);
      checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
      checkOutput("reset_timeout_cnt", 32'(timeout_cnt), 32'h0);

      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].doneK,
                       vecs[v].hold, vecs[v].wrong, vecs[v].expData, vecs[v].expErr);
      end

      // Done strobes while idle must not start anything
      idleBad = 0;
      for (int i = 0; i < 6; i++) begin
         bus.reg_rd_done_out = 1'b1;
         bus.reg_wr_done     = (i % 2) == 1;
         bus.mac_regdout     = $urandom;
         @(negedge reg_clk);
         if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
             bus.reg_rd_start !== 1'b0 || bus.reg_wr_start !== 1'b0)
            idleBad++;
      end
      bus.reg_rd_done_out = 1'b0;
      bus.reg_wr_done     = 1'b0;
      checkOutput("idle_done_ignored", 32'(idleBad), 32'd0);
      checkOutput("timeout_cnt_kept", 32'(timeout_cnt), 32'(expToCnt));

      // Randomized transactions against the transaction-level rules
      for (int t = 0; t < 24; t++) begin
         rWr    = 1'($urandom_range(0, 1));
         rAddr  = 16'($urandom);
         rWdata = $urandom;
         rRdata = $urandom;
         rK     = $urandom_range(0, TIMEOUT_CYC + 3);
         rHold  = $urandom_range(0, 3);
         rWrong = 1'($urandom_range(0, 1));
         rExpErr  = !(rK >= 1 && rK <= TIMEOUT_CYC);
         rExpData = rExpErr ? 32'hFFFFFFFF : (rWr ? 32'h0 : rRdata);
         applyStimulus(rWr, rAddr, rWdata, rRdata, rK, rHold, rWrong, rExpData, rExpErr);
      end

      // Reset in the middle of WAIT drops the transaction
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 16'h1234;
      @(negedge reg_clk);
      bus.req_valid = 1'b0;
      repeat (SETUP_CYC + 3) @(negedge reg_clk);
      checkOutput("busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge reg_clk);
      reset = 1'b0;
      expToCnt = 0;
      checkOutput("reset_mid_ctrl", 32'({busy, bus.rsp_valid, bus.req_ready}), 32'b001);
      checkOutput("reset_mid_host_addr", 32'(bus.host_addr), 32'h0);
      checkOutput("reset_mid_timeout_cnt", 32'(timeout_cnt), 32'h0);
      bus.reg_rd_done_out = 1'b1;
      bus.mac_regdout     = 32'hDEADBEEF;
      @(negedge reg_clk);
      bus.reg_rd_done_out = 1'b0;
      idleBad = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.reg_rd_start !== 1'b0) idleBad++;
         @(negedge reg_clk);
      end
      checkOutput("late_done_ignored", 32'(idleBad), 32'd0);

      // Enough timeouts to drive the counter into saturation
      for (int i = 0; i < 257; i++) begin
         applyStimulus(1'b0, 16'(i), 32'h0, 32'h0, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b1);
      end
      checkOutput("timeout_cnt_saturated", 32'(timeout_cnt), 32'd255);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
